// File: rtl/reorder_buf_pkg.sv
// reorder_buf_pkg: shared types and sizes for the reorder buffer
package reorder_buf_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int PHY_REG_W = 6;
  localparam int PC_W = 32;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [PHY_REG_W-1:0] phy_reg_t;
  typedef logic [PC_W-1:0] pc_t;
  typedef logic [3:0] fu_op_t;
  typedef logic [2:0] fu_sel_t;
  typedef logic [31:0] imm_t;
endpackage

// File: rtl/reorder_buf_lane.sv
// lane_prefix: exclusive prefix count and popcount over a lane mask
//   v   : lane mask
//   pre : number of set lanes strictly below each lane
//   cnt : total set lanes
module lane_prefix #(
  parameter int N = 3,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         v,
  output logic [N-1:0][CW-1:0] pre,
  output logic [CW-1:0]        cnt
);
  always_comb begin
    cnt = '0;
    for (int k = 0; k < N; k++) begin
      pre[k] = cnt;
      cnt = cnt + CW'(v[k]);
    end
  end
endmodule

// File: rtl/reorder_buf.sv
// reorder_buf: circular in-order retirement buffer with multi-lane submit, complete and retire
//   clk, rst_n          : clock, synchronous active-low reset
//   sub_*               : per-lane renamed instructions; sub_accept gates a whole group
//   alloc_idx           : entry assigned to each valid submit lane (packed in lane order)
//   cdb_valid, cdb_idx  : completion lanes marking entries done
//   flush               : squash every in-flight entry
//   ret_*               : in-order retire group, combinational from registered state
//   count               : occupied entries
module reorder_buf
  import reorder_buf_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = ROB_DEPTH,
  parameter int CDB_W = 3,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic     [WIDTH-1:0]        sub_valid,
  input  fu_op_t   [WIDTH-1:0]        sub_fu_op,
  input  fu_sel_t  [WIDTH-1:0]        sub_fu_sel,
  input  pc_t      [WIDTH-1:0]        sub_pc,
  input  imm_t     [WIDTH-1:0]        sub_imm,
  input  phy_reg_t [WIDTH-1:0][1:0]   sub_src,
  input  logic     [WIDTH-1:0][1:0]   sub_ready,
  input  phy_reg_t [WIDTH-1:0]        sub_dst,
  input  phy_reg_t [WIDTH-1:0]        sub_dst_old,
  output logic                        sub_accept,
  output logic     [WIDTH-1:0][IW-1:0] alloc_idx,
  input  logic     [CDB_W-1:0]        cdb_valid,
  input  logic     [CDB_W-1:0][IW-1:0] cdb_idx,
  input  logic                        flush,
  output logic     [WIDTH-1:0]        ret_valid,
  output phy_reg_t [WIDTH-1:0]        ret_dst,
  output phy_reg_t [WIDTH-1:0]        ret_dst_old,
  output pc_t      [WIDTH-1:0]        ret_pc,
  output logic     [IW:0]             count
);
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IW:0] count_q, count_d;
  logic [DEPTH-1:0] done_q, done_d, occ;
  pc_t [DEPTH-1:0] pc_q, pc_d;
  phy_reg_t [DEPTH-1:0] dst_q, dst_d, dst_old_q, dst_old_d;
  logic [WIDTH-1:0][CW-1:0] alloc_pre, ret_pre;
  logic [CW-1:0] n_valid, n_ret;
  logic do_sub, ret_ok;
  lane_prefix #(.N(WIDTH)) u_alloc (.v(sub_valid), .pre(alloc_pre), .cnt(n_valid));
  lane_prefix #(.N(WIDTH)) u_ret (.v(ret_valid), .pre(ret_pre), .cnt(n_ret));
  assign count = count_q;
  assign sub_accept = count_q <= (IW+1)'(DEPTH - WIDTH);
  assign do_sub = sub_accept && |sub_valid && !flush;
  // An index is occupied when its distance from head is below count.
  always_comb
    for (int i = 0; i < DEPTH; i++)
      occ[i] = {1'b0, IW'(i) - head_q} < count_q;
  // Retire lane k needs every entry from head up to head+k done.
  always_comb begin
    ret_ok = !flush;
    for (int k = 0; k < WIDTH; k++) begin
      ret_ok = ret_ok && (count_q > (IW+1)'(k)) && done_q[head_q + IW'(k)];
      ret_valid[k] = ret_ok;
      ret_pc[k] = pc_q[head_q + IW'(k)];
      ret_dst[k] = dst_q[head_q + IW'(k)];
      ret_dst_old[k] = dst_old_q[head_q + IW'(k)];
    end
  end
  // Completion first, then freeing retired entries, so a stale done bit never survives reuse.
  always_comb begin
    head_d = head_q + IW'(n_ret);
    tail_d = tail_q + (do_sub ? IW'(n_valid) : '0);
    count_d = count_q + (do_sub ? (IW+1)'(n_valid) : '0) - (IW+1)'(n_ret);
    done_d = done_q;
    pc_d = pc_q;
    dst_d = dst_q;
    dst_old_d = dst_old_q;
    for (int j = 0; j < CDB_W; j++)
      if (cdb_valid[j] && occ[cdb_idx[j]] && !flush) done_d[cdb_idx[j]] = 1'b1;
    for (int k = 0; k < WIDTH; k++)
      if (ret_valid[k]) done_d[head_q + IW'(k)] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      alloc_idx[k] = tail_q + IW'(alloc_pre[k]);
      if (do_sub && sub_valid[k]) begin
        done_d[alloc_idx[k]] = 1'b0;
        pc_d[alloc_idx[k]] = sub_pc[k];
        dst_d[alloc_idx[k]] = sub_dst[k];
        dst_old_d[alloc_idx[k]] = sub_dst_old[k];
      end
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      done_d = '0;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      done_q <= done_d;
    end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    dst_q <= dst_d;
    dst_old_q <= dst_old_d;
  end
endmodule

// File: tb/tb_reorder_buf.sv
// tb_reorder_buf: directed self-checking bench for reorder_buf
module tb_reorder_buf;
  import reorder_buf_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] sub_valid;
  fu_op_t [2:0] sub_fu_op;
  fu_sel_t [2:0] sub_fu_sel;
  pc_t [2:0] sub_pc;
  imm_t [2:0] sub_imm;
  phy_reg_t [2:0][1:0] sub_src;
  logic [2:0][1:0] sub_ready;
  phy_reg_t [2:0] sub_dst, sub_dst_old;
  logic sub_accept;
  logic [2:0][4:0] alloc_idx;
  logic [2:0] cdb_valid;
  logic [2:0][4:0] cdb_idx;
  logic flush;
  logic [2:0] ret_valid;
  phy_reg_t [2:0] ret_dst, ret_dst_old;
  pc_t [2:0] ret_pc;
  logic [5:0] count;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  reorder_buf dut (
    .clk(clk), .rst_n(rst_n), .sub_valid(sub_valid), .sub_fu_op(sub_fu_op),
    .sub_fu_sel(sub_fu_sel), .sub_pc(sub_pc), .sub_imm(sub_imm), .sub_src(sub_src),
    .sub_ready(sub_ready), .sub_dst(sub_dst), .sub_dst_old(sub_dst_old),
    .sub_accept(sub_accept), .alloc_idx(alloc_idx), .cdb_valid(cdb_valid),
    .cdb_idx(cdb_idx), .flush(flush), .ret_valid(ret_valid), .ret_dst(ret_dst),
    .ret_dst_old(ret_dst_old), .ret_pc(ret_pc), .count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    sub_valid = '0; sub_fu_op = '0; sub_fu_sel = '0; sub_pc = '0; sub_imm = '0;
    sub_src = '0; sub_ready = '0; sub_dst = '0; sub_dst_old = '0;
    cdb_valid = '0; cdb_idx = '0; flush = 1'b0;
  endtask
  task automatic cdb(input logic [2:0] v, input int a, input int b, input int c);
    cdb_valid = v;
    cdb_idx[0] = 5'(a);
    cdb_idx[1] = 5'(b);
    cdb_idx[2] = 5'(c);
  endtask
  initial begin
    clr();
    rst_n = 1'b0;
    sub_valid = 3'b111;
    flush = 1'b1;
    step();
    step();
    clr();
    rst_n = 1'b1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_accept", 32'(sub_accept), 1);
    check("rst_ret_valid", 32'(ret_valid), 0);
    sub_valid = 3'b101;
    sub_dst_old = {6'd12, 6'd11, 6'd10};
    #1;
    check("pack_alloc0", 32'(alloc_idx[0]), 0);
    check("pack_alloc2", 32'(alloc_idx[2]), 1);
    step(); clr(); #1;
    check("pack_count", 32'(count), 2);
    sub_valid = 3'b111;
    sub_dst_old = {6'd22, 6'd21, 6'd20};
    #1;
    check("tail2_alloc0", 32'(alloc_idx[0]), 2);
    check("tail2_alloc2", 32'(alloc_idx[2]), 4);
    step(); clr();
    cdb(3'b001, 2, 0, 0);
    step(); clr(); #1;
    check("ooo_after2", 32'(ret_valid), 0);
    cdb(3'b001, 1, 0, 0);
    step(); clr(); #1;
    check("ooo_after1", 32'(ret_valid), 0);
    cdb(3'b001, 0, 0, 0);
    #1;
    check("ooo_same_cycle", 32'(ret_valid), 0);
    step(); clr(); #1;
    check("ooo_ret_valid", 32'(ret_valid), 3'b111);
    check("ooo_dst_old0", 32'(ret_dst_old[0]), 10);
    check("ooo_dst_old1", 32'(ret_dst_old[1]), 12);
    check("ooo_dst_old2", 32'(ret_dst_old[2]), 20);
    check("ooo_count", 32'(count), 5);
    step(); #1;
    check("ooo_count_after", 32'(count), 2);
    check("ooo_ret_after", 32'(ret_valid), 0);
    sub_valid = 3'b111;
    cdb(3'b011, 3, 3, 0);
    step(); clr(); #1;
    check("dup_count", 32'(count), 5);
    check("dup_ret_valid", 32'(ret_valid), 3'b001);
    flush = 1'b1;
    sub_valid = 3'b111;
    cdb(3'b001, 4, 0, 0);
    #1;
    check("flush_ret_valid", 32'(ret_valid), 0);
    step(); clr(); #1;
    check("flush_count", 32'(count), 0);
    check("flush_accept", 32'(sub_accept), 1);
    check("flush_ret_after", 32'(ret_valid), 0);
    cdb(3'b011, 3, 0, 0);
    step(); clr(); #1;
    check("stale_ret_valid", 32'(ret_valid), 0);
    check("stale_count", 32'(count), 0);
    sub_valid = 3'b111;
    #1;
    check("fill_alloc0", 32'(alloc_idx[0]), 0);
    repeat (10) step();
    clr(); #1;
    check("fill_count", 32'(count), 30);
    check("fill_accept", 32'(sub_accept), 0);
    sub_valid = 3'b111;
    cdb(3'b001, 0, 0, 0);
    step(); clr(); #1;
    check("full_count_hold", 32'(count), 30);
    check("full_accept_hold", 32'(sub_accept), 0);
    check("full_ret_valid", 32'(ret_valid), 3'b001);
    step(); #1;
    check("ret1_count", 32'(count), 29);
    check("ret1_accept", 32'(sub_accept), 1);
    sub_valid = 3'b111;
    #1;
    check("wrap_alloc0", 32'(alloc_idx[0]), 30);
    check("wrap_alloc1", 32'(alloc_idx[1]), 31);
    check("wrap_alloc2", 32'(alloc_idx[2]), 0);
    step(); clr(); #1;
    check("max_count", 32'(count), 32);
    check("max_accept", 32'(sub_accept), 0);
    flush = 1'b1;
    step(); clr(); #1;
    check("flush2_count", 32'(count), 0);
    sub_valid = 3'b111;
    repeat (10) step();
    clr();
    for (int i = 0; i < 10; i++) begin
      cdb(3'b111, 3 * i, 3 * i + 1, 3 * i + 2);
      step();
    end
    clr();
    step(); #1;
    check("drain_count", 32'(count), 0);
    sub_valid = 3'b111;
    sub_pc = {32'h308, 32'h304, 32'h300};
    #1;
    check("h30_alloc0", 32'(alloc_idx[0]), 30);
    check("h30_alloc1", 32'(alloc_idx[1]), 31);
    check("h30_alloc2", 32'(alloc_idx[2]), 0);
    step(); clr();
    cdb(3'b111, 30, 31, 0);
    step(); clr(); #1;
    check("h30_ret_valid", 32'(ret_valid), 3'b111);
    check("h30_pc0", ret_pc[0], 32'h300);
    check("h30_pc1", ret_pc[1], 32'h304);
    check("h30_pc2", ret_pc[2], 32'h308);
    step(); #1;
    check("h30_count", 32'(count), 0);
    sub_valid = 3'b111;
    repeat (3) step();
    sub_valid = 3'b001;
    step(); clr(); #1;
    check("c10_count", 32'(count), 10);
    cdb(3'b011, 1, 2, 0);
    step(); clr(); #1;
    check("c10_ret_valid", 32'(ret_valid), 3'b011);
    sub_valid = 3'b111;
    step(); clr(); #1;
    check("c10_next_count", 32'(count), 11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reorder_buf.md
REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 3: lanes per submit, complete and retire group.
REQ-002 SHALL have parameter DEPTH, default 32: entry count, power of two.
REQ-003 SHALL have parameter CDB_W, default 3: completion lanes.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 sub_valid, sub_fu_op, sub_fu_sel, sub_pc, sub_imm, sub_src, sub_ready, sub_dst, sub_dst_old  input  per-lane fields of the submit bus (WIDTH lanes): renamed instructions from the map table.
REQ-007 sub_accept  output  1: buffer can take a full WIDTH group this cycle.
REQ-008 alloc_idx  output  WIDTH x log2(DEPTH): entry index assigned to each submit lane.
REQ-009 cdb_valid  input  CDB_W: completion lane valid.
REQ-010 cdb_idx  input  CDB_W x log2(DEPTH): entry index being completed.
REQ-011 flush  input  1: squash all in-flight entries.
REQ-012 ret_valid  output  WIDTH: lane retires this cycle.
REQ-013 ret_dst, ret_dst_old  output  WIDTH x phy_reg_t: retired mapping; dst_old is returned to the free list.
REQ-014 ret_pc  output  WIDTH x pc_t: retired instruction PC.
REQ-015 count  output  log2(DEPTH)+1: occupied entries.

Function
REQ-016 Storage SHALL be a circular queue with head, tail and count registers; indices SHALL wrap modulo DEPTH.
REQ-017 sub_accept SHALL be 1 iff registered (DEPTH - count) >= WIDTH; no partial acceptance.
REQ-018 A submit SHALL occur when sub_accept=1 and any sub_valid bit is set; only valid lanes are allocated.
REQ-019 Valid lanes SHALL pack contiguously in lane order: alloc_idx[k] = tail + (number of valid lanes below k), mod DEPTH; alloc_idx of an invalid lane is don't-care.
REQ-020 A new entry SHALL store pc, dst and dst_old, with done=0.
REQ-021 A cdb_valid lane SHALL set done of entry cdb_idx at the next edge; completion to an unoccupied index SHALL be ignored; duplicate indices across lanes are legal.
REQ-022 Retire SHALL be combinational from registered state: ret_valid[k]=1 iff count>k and entries head..head+k are all done.
REQ-023 Retired entries SHALL free at the edge they are presented; head += n_ret and count += n_alloc - n_ret in the same cycle.
REQ-024 A completion in cycle N SHALL make the entry retirable no earlier than cycle N+1.
REQ-025 A submit and a retire in the same cycle SHALL both take effect; the submit is gated only by registered count.
REQ-026 flush SHALL dominate: ret_valid forced to 0 in the flush cycle, submit and completion ignored; next cycle head=tail=count=0 and all done bits clear.
REQ-027 count SHALL never exceed DEPTH; at count=DEPTH, sub_accept=0 and tail==head.

Reset
REQ-028 While rst_n=0 at an edge: head=tail=count=0 and all done bits cleared.
REQ-029 After reset: sub_accept=1, ret_valid=0, count=0; ret_dst, ret_dst_old and ret_pc are don't-care while ret_valid=0.
REQ-030 Reset SHALL override flush, submit and completion in the same cycle.

Structure
REQ-031 rob_idx_t, ROB_DEPTH and ROB_IDX_W SHALL live in the shared package alongside phy_reg_t and pc_t.
REQ-032 The allocation prefix-sum and popcount SHALL be one sub-module, lane_prefix, reused for retire counting.
REQ-033 Payload storage SHALL be flops, not RAM, to allow same-cycle multi-lane reads.

Verification
REQ-034 After reset, submit sub_valid=3'b101 -> alloc_idx[0]=0, alloc_idx[2]=1, count=2 next cycle, tail=2.
REQ-035 Fill to count=30 -> sub_accept=0; retire 1 -> count=29 and sub_accept=1 the next cycle.
REQ-036 Entries 0..2 allocated, complete 2 then 1 (both retire nothing), then complete 0 -> next cycle ret_valid=3'b111 with dst_old in order.
REQ-037 head=30, submit 3 lanes -> alloc_idx = 30, 31, 0; complete all three -> retire in order 30, 31, 0.
REQ-038 count=5, flush together with submit and cdb -> ret_valid=0 that cycle; next cycle count=0, sub_accept=1, old indices not retirable.
REQ-039 Same cycle: submit 3, retire 2, at count=10 -> count=11 next cycle.
